// File: rtl/fp_wb_pkg.sv
// Shared types and defaults for the FP writeback arbiter: result entry layout
// and the round-robin index helper.
package fp_wb_pkg;

   localparam int unsigned NUM_SRC_DEF    = 3;
   localparam int unsigned FIFO_DEPTH_DEF = 2;
   localparam int unsigned DATA_W_DEF     = 16;
   localparam int unsigned RD_W           = 5;
   localparam int unsigned NUM_FPR        = 32;

   typedef logic [RD_W-1:0] fpr_idx_t;

   typedef struct packed {
      fpr_idx_t              rd;
      logic [DATA_W_DEF-1:0] data;
   } fp_wb_entry_t;

   // (base + off) mod n, for base < n and off <= n
   function automatic int unsigned wrap_idx(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
      int unsigned sum;
      sum = base + off;
      return (sum >= n) ? (sum - n) : sum;
   endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Per-source result buffer: small circular FIFO whose head is visible
// combinationally so the arbiter can grant and pop in the same cycle.
module fp_wb_fifo
   import fp_wb_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   parameter type         entry_t = fp_wb_entry_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   output entry_t head,
   output logic   empty,
   output logic   full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == FULL_CNT);
   // full is judged on pre-pop occupancy, so a push never rides on a same-cycle pop
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback arbiter: buffers results from several units,
// grants up to two heads per cycle round-robin, and keeps a pending-write scoreboard.
module fp_wb_arbiter
   import fp_wb_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_SRC-1:0]              src_valid,
   output logic [NUM_SRC-1:0]              src_ready,
   input  logic [NUM_SRC-1:0][RD_W-1:0]    src_rd,
   input  logic [NUM_SRC-1:0][DATA_W-1:0]  src_data,
   input  logic                            issue_valid,
   input  logic [RD_W-1:0]                 issue_rd,
   output logic [NUM_FPR-1:0]              busy,
   output logic                            we0,
   output logic [RD_W-1:0]                 waddr0,
   output logic [DATA_W-1:0]               wdata0,
   output logic                            we1,
   output logic [RD_W-1:0]                 waddr1,
   output logic [DATA_W-1:0]               wdata1,
   output logic                            wb_idle
);

   localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef struct packed {
      fpr_idx_t          rd;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t             push_ent [NUM_SRC];
   entry_t             head     [NUM_SRC];
   logic [NUM_SRC-1:0] empty, full, grant;

   for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_src
      assign push_ent[g] = '{rd: src_rd[g], data: src_data[g]};

      fp_wb_fifo #(
         .DEPTH   (FIFO_DEPTH),
         .entry_t (entry_t)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (src_valid[g]),
         .push_data (push_ent[g]),
         .pop       (grant[g]),
         .head      (head[g]),
         .empty     (empty[g]),
         .full      (full[g])
      );
   end

   assign src_ready = ~full;

   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               we0_q, we0_d, we1_q, we1_d;
   fpr_idx_t           waddr0_q, waddr0_d, waddr1_q, waddr1_d;
   logic [DATA_W-1:0]  wdata0_q, wdata0_d, wdata1_q, wdata1_d;
   logic [NUM_FPR-1:0] busy_q, busy_d;

   logic [SRC_W-1:0]   idx, last_src;
   logic [1:0]         n_grant;
   fpr_idx_t           first_rd;

   // Grant scan: a second head targeting the same rd as port 0 waits its turn.
   always_comb begin
      grant    = '0;
      idx      = '0;
      last_src = rr_ptr_q;
      n_grant  = '0;
      first_rd = '0;
      we0_d    = 1'b0;
      we1_d    = 1'b0;
      waddr0_d = waddr0_q;
      wdata0_d = wdata0_q;
      waddr1_d = waddr1_q;
      wdata1_d = wdata1_q;
      rr_ptr_d = rr_ptr_q;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         idx = SRC_W'(wrap_idx(int'(rr_ptr_q), k, NUM_SRC));
         if (!empty[idx] && n_grant < 2'd2) begin
            if (n_grant == 2'd0) begin
               grant[idx] = 1'b1;
               we0_d      = 1'b1;
               waddr0_d   = head[idx].rd;
               wdata0_d   = head[idx].data;
               first_rd   = head[idx].rd;
               last_src   = idx;
               n_grant    = 2'd1;
            end else if (head[idx].rd != first_rd) begin
               grant[idx] = 1'b1;
               we1_d      = 1'b1;
               waddr1_d   = head[idx].rd;
               wdata1_d   = head[idx].data;
               last_src   = idx;
               n_grant    = 2'd2;
            end
         end
      end
      if (n_grant != 2'd0) begin
         rr_ptr_d = SRC_W'(wrap_idx(int'(last_src), 1, NUM_SRC));
      end
   end

   // Clears come from the registered write ports; an issue to the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (we0_q) busy_d[waddr0_q] = 1'b0;
      if (we1_q) busy_d[waddr1_q] = 1'b0;
      if (issue_valid) busy_d[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         we0_q    <= 1'b0;
         we1_q    <= 1'b0;
         waddr0_q <= '0;
         waddr1_q <= '0;
         wdata0_q <= '0;
         wdata1_q <= '0;
         busy_q   <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         we0_q    <= we0_d;
         we1_q    <= we1_d;
         waddr0_q <= waddr0_d;
         waddr1_q <= waddr1_d;
         wdata0_q <= wdata0_d;
         wdata1_q <= wdata1_d;
         busy_q   <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign we0     = we0_q;
   assign waddr0  = waddr0_q;
   assign wdata0  = wdata0_q;
   assign we1     = we1_q;
   assign waddr1  = waddr1_q;
   assign wdata1  = wdata1_q;
   assign wb_idle = (&empty) && !we0_q && !we1_q;

endmodule
